vote_result_reader: RTL
=======================

Name: vote_result_reader

Overview:
Reads the four 8-bit candidate tallies in result mode (mode=1) and reports them. On a start request it snapshots all tallies and finds the winner or a tie with a sequential comparator. It then streams an 11-byte framed report over a valid/ready byte interface to the display/UART side of the voting machine.

Parameters:
CNT_W, 8, width of each tally input and of out_data
HDR, 8'hA5, frame header byte

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mode  input  1  0 = voting, 1 = result; start is honoured only when mode=1
start  input  1  report request, level-sampled in IDLE
cand1_vote_recvd  input  CNT_W  tally, candidate 1
cand2_vote_recvd  input  CNT_W  tally, candidate 2
cand3_vote_recvd  input  CNT_W  tally, candidate 3
cand4_vote_recvd  input  CNT_W  tally, candidate 4
out_data  output  8  report byte
out_valid  output  1  out_data valid
out_ready  input  1  sink accepts byte
busy  output  1  high in CMP and SEND
winner  output  3  winning candidate ID 1..4; 0 = none or tie
tie  output  1  two or more candidates share a nonzero maximum
done  output  1  one-cycle pulse at end of report

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. out_data=0, out_valid=0, busy=0, winner=0, tie=0, done=0. Snapshot, comparator and checksum registers are cleared.
- Reset asserted mid-report aborts the report immediately. No partial-frame recovery.
- IDLE: at a rising edge with start=1 and mode=1, capture all four tallies into snapshot registers and go to CMP with idx=2. Preload best=snap1, best_id=1, tie_r=0.
- start is ignored when mode=0 or when not in IDLE.
- CMP, one candidate per cycle for idx=2,3,4:
  - snap[idx] > best: best=snap[idx], best_id=idx, tie_r=0.
  - snap[idx] == best: tie_r=1.
  - Comparison is unsigned.
- After the idx=4 edge, go to SEND:
  - If best==0: winner=0, tie=0.
  - Else if tie_r: winner=0, tie=1.
  - Else: winner=best_id, tie=0.
  - winner and tie hold until the next entry to SEND or reset.
- Latency: out_valid rises 4 clock edges after the edge that sampled start.
- SEND frame, in order, 11 bytes:
  - HDR
  - 1, snap1
  - 2, snap2
  - 3, snap3
  - 4, snap4
  - winner byte ({5'b0, winner})
  - checksum = XOR of the 10 preceding bytes
- Handshake:
  - A byte transfers on an edge where out_valid=1 and out_ready=1.
  - While out_valid=1 and out_ready=0, out_data is held stable and out_valid stays high.
  - Back-to-back transfers run at one byte per cycle when out_ready is held high.
  - The checksum accumulates on each transfer.
- End of frame: on the checksum-byte transfer edge, state returns to IDLE and out_valid drops. done=1 for exactly the following cycle. A new start is accepted in IDLE from that cycle onward.
- Snapshot isolation:
  - Tally changes after the capture edge do not affect the current report.
  - mode changing mid-report does not abort it; the frame always completes.
- busy=1 from the capture edge until the return to IDLE.

Test Plan:
- Tallies 2,9,4,0; mode=1; start pulse; out_ready=1 -> out_valid rises 4 edges after start; bytes A5 01 02 02 09 03 04 04 00 02 AC; winner=2, tie=0; done pulses once.
- Tallies 3,5,5,1 -> winner byte 00, checksum A3; winner=0, tie=1.
- Tallies all 0 -> bytes A5 01 00 02 00 03 00 04 00 00 A1; winner=0, tie=0.
- Tallies 0,0,0,FF, with out_ready toggling randomly -> out_data stable while stalled; no byte lost or duplicated; winner=4. Tallies changed after capture do not alter the frame.
- Illegal starts:
  - start with mode=0 -> no activity, busy=0.
  - start held high during SEND -> ignored.
  - start still high in IDLE after done -> second report begins.
- reset driven low mid-SEND (byte 5) with no clock edge -> out_valid, busy, winner, tie fall to 0 immediately; next start produces a full fresh frame.

Source files
------------

// File: rtl/vote_result_reader.sv
// Result-mode report engine: snapshots four tallies, picks the winner (or a tie)
// one candidate per cycle, then streams an 11-byte framed report over valid/ready.
module vote_result_reader #(
  parameter int         CNT_W = 8,
  parameter logic [7:0] HDR   = 8'hA5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mode,
  input  logic             start,
  input  logic [CNT_W-1:0] cand1_vote_recvd,
  input  logic [CNT_W-1:0] cand2_vote_recvd,
  input  logic [CNT_W-1:0] cand3_vote_recvd,
  input  logic [CNT_W-1:0] cand4_vote_recvd,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [2:0]       winner,
  output logic             tie,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_SEND} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_snap [4];
  logic [CNT_W-1:0] r_best;
  logic [2:0]       r_best_id;
  logic             r_tie;
  logic [1:0]       r_idx;
  logic [3:0]       r_byte;
  logic [7:0]       r_chk;

  logic [CNT_W-1:0] w_cur;
  logic [CNT_W-1:0] w_best_nx;
  logic [2:0]       w_id_nx;
  logic             w_tie_nx;
  logic [3:0]       w_byte_nx;
  logic [7:0]       w_data_nx;

  // Comparator step for the candidate at r_idx (zero-based snapshot index).
  always_comb begin
    w_cur     = r_snap[r_idx];
    w_best_nx = r_best;
    w_id_nx   = r_best_id;
    w_tie_nx  = r_tie;
    if (w_cur > r_best) begin
      w_best_nx = w_cur;
      w_id_nx   = {1'b0, r_idx} + 3'd1;
      w_tie_nx  = 1'b0;
    end else if (w_cur == r_best) begin
      w_tie_nx  = 1'b1;
    end
  end

  // Next frame byte; the checksum byte folds in the byte currently transferring.
  always_comb begin
    w_byte_nx = r_byte + 4'd1;
    case (w_byte_nx)
      4'd1:    w_data_nx = 8'd1;
      4'd2:    w_data_nx = 8'(r_snap[0]);
      4'd3:    w_data_nx = 8'd2;
      4'd4:    w_data_nx = 8'(r_snap[1]);
      4'd5:    w_data_nx = 8'd3;
      4'd6:    w_data_nx = 8'(r_snap[2]);
      4'd7:    w_data_nx = 8'd4;
      4'd8:    w_data_nx = 8'(r_snap[3]);
      4'd9:    w_data_nx = {5'b0, winner};
      4'd10:   w_data_nx = r_chk ^ out_data;
      default: w_data_nx = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      for (int i = 0; i < 4; i++) r_snap[i] <= '0;
      r_best    <= '0;
      r_best_id <= 3'd0;
      r_tie     <= 1'b0;
      r_idx     <= 2'd0;
      r_byte    <= 4'd0;
      r_chk     <= 8'd0;
      out_data  <= 8'd0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      winner    <= 3'd0;
      tie       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && mode) begin
            r_snap[0] <= cand1_vote_recvd;
            r_snap[1] <= cand2_vote_recvd;
            r_snap[2] <= cand3_vote_recvd;
            r_snap[3] <= cand4_vote_recvd;
            r_best    <= cand1_vote_recvd;
            r_best_id <= 3'd1;
            r_tie     <= 1'b0;
            r_idx     <= 2'd1;
            busy      <= 1'b1;
            r_state   <= S_CMP;
          end
        end
        S_CMP: begin
          r_best    <= w_best_nx;
          r_best_id <= w_id_nx;
          r_tie     <= w_tie_nx;
          r_idx     <= r_idx + 2'd1;
          if (r_idx == 2'd3) begin
            r_state <= S_SEND;
            r_byte  <= 4'd0;
            r_chk   <= 8'd0;
            if (w_best_nx == '0) begin
              winner <= 3'd0;
              tie    <= 1'b0;
            end else if (w_tie_nx) begin
              winner <= 3'd0;
              tie    <= 1'b1;
            end else begin
              winner <= w_id_nx;
              tie    <= 1'b0;
            end
          end
        end
        S_SEND: begin
          // First SEND cycle presents the header; afterwards advance on each transfer.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= HDR;
            r_byte    <= 4'd0;
          end else if (out_ready) begin
            r_chk <= r_chk ^ out_data;
            if (r_byte == 4'd10) begin
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_byte   <= w_byte_nx;
              out_data <= w_data_nx;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
